// File: rtl/caravel_frequency_counter.sv
// caravel_frequency_counter: counts rising edges of mprj_io[8] over a fixed
// window of clock cycles and shows the result (0..99) on a two-digit,
// time-multiplexed seven-segment display driven from mprj_io[16:9].
// Optional feature, enabled by defining FREQ_COUNTER_FLASH_CFG_EN: after reset
// the window length is read from SPI flash (read command 0x03, address 0,
// four bytes big-endian) before counting starts.
module caravel_frequency_counter #(
    parameter int unsigned DEFAULT_PERIOD = 1000
) (
    input  logic        vddio,
    input  logic        vssio,
    input  logic        vdda,
    input  logic        vssa,
    input  logic        vccd,
    input  logic        vssd,
    input  logic        vdda1,
    input  logic        vdda2,
    input  logic        vssa1,
    input  logic        vssa2,
    input  logic        vccd1,
    input  logic        vccd2,
    input  logic        vssd1,
    input  logic        vssd2,
    input  logic        clock,
    input  logic        resetb,
    inout  wire  [37:0] mprj_io,
    inout  wire         gpio,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1
);

    localparam logic [31:0] DEF_PERIOD = DEFAULT_PERIOD;

    // Clamp the raw window count to the two-digit display range.
    function automatic logic [6:0] sat99(input logic [31:0] v);
        return (v > 32'd99) ? 7'd99 : v[6:0];
    endfunction

    // Active-high segments, bit0 = a .. bit6 = g.
    function automatic logic [6:0] seg_encode(input logic [6:0] v);
        case (v)
            7'd0:    return 7'h3F;
            7'd1:    return 7'h06;
            7'd2:    return 7'h5B;
            7'd3:    return 7'h4F;
            7'd4:    return 7'h66;
            7'd5:    return 7'h6D;
            7'd6:    return 7'h7D;
            7'd7:    return 7'h07;
            7'd8:    return 7'h7F;
            7'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        sync_prev_q, sync_prev_d;
    logic [31:0] win_q, win_d;
    logic [31:0] edge_cnt_q, edge_cnt_d;
    logic [6:0]  latch_q, latch_d;
    logic [6:0]  display_q, display_d;
    logic        digit_q, digit_d;
    logic [31:0] edge_sum;
    logic        rise;
    logic        count_en;
    logic [31:0] period_w;
    logic [6:0]  seg_w;

    // Pad mapping: only the display pins are driven, everything else floats.
    assign mprj_io[37:17] = {21{1'bz}};
    assign mprj_io[16]    = digit_q;
    assign mprj_io[15:9]  = seg_w;
    assign mprj_io[8]     = 1'bz;
    assign mprj_io[7:0]   = {8{1'bz}};
    assign gpio           = 1'bz;

    logic unused_pins;
    assign unused_pins = &{vddio, vssio, vdda, vssa, vccd, vssd, vdda1, vdda2,
                           vssa1, vssa2, vccd1, vccd2, vssd1, vssd2, gpio,
                           mprj_io[37:9], mprj_io[7:0]};

    assign rise = sync2_q & ~sync_prev_q;

`ifdef FREQ_COUNTER_FLASH_CFG_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        fclk_q, fclk_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] cmd_sr_q, cmd_sr_d;
    logic [31:0] rx_q, rx_d;
    logic [31:0] period_q, period_d;

    // Erased or nonsensical flash contents fall back to the built-in period.
    function automatic logic [31:0] pick_period(input logic [31:0] v);
        if (v == 32'd0 || v == 32'd1 || v == 32'hFFFF_FFFF)
            return DEF_PERIOD;
        return v;
    endfunction

    // Loader state register.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Loader next state: one idle cycle, 64 SPI bits, then run forever.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_XFER;
            S_XFER:  if (fclk_q && bit_cnt_q == 7'd64) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Loader outputs: chip select low only while the transfer is in flight.
    always_comb begin
        flash_csb = (state_q != S_XFER);
        flash_clk = fclk_q;
        flash_io0 = (state_q == S_XFER) ? cmd_sr_q[31] : 1'b0;
    end

    // SPI shifter: SCK rises on odd cycles (MISO sampled), falls on even (MOSI shifts).
    always_comb begin
        fclk_d    = fclk_q;
        bit_cnt_d = bit_cnt_q;
        cmd_sr_d  = cmd_sr_q;
        rx_d      = rx_q;
        period_d  = period_q;
        if (state_q == S_XFER) begin
            if (!fclk_q) begin
                fclk_d    = 1'b1;
                bit_cnt_d = bit_cnt_q + 7'd1;
                if (bit_cnt_q >= 7'd32) rx_d = {rx_q[30:0], flash_io1};
            end else begin
                fclk_d   = 1'b0;
                cmd_sr_d = {cmd_sr_q[30:0], 1'b0};
                if (bit_cnt_q == 7'd64) period_d = pick_period(rx_q);
            end
        end
    end

    // SPI shifter registers; the command word is 0x03 followed by address 0.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            fclk_q    <= 1'b0;
            bit_cnt_q <= 7'd0;
            cmd_sr_q  <= 32'h0300_0000;
            rx_q      <= 32'd0;
            period_q  <= DEF_PERIOD;
        end else begin
            fclk_q    <= fclk_d;
            bit_cnt_q <= bit_cnt_d;
            cmd_sr_q  <= cmd_sr_d;
            rx_q      <= rx_d;
            period_q  <= period_d;
        end
    end

    assign count_en = (state_q == S_RUN);
    assign period_w = period_q;
`else
    assign count_en  = 1'b1;
    assign period_w  = DEF_PERIOD;
    assign flash_csb = 1'b1;
    assign flash_clk = 1'b0;
    assign flash_io0 = 1'b0;

    logic unused_flash;
    assign unused_flash = flash_io1;
`endif

    // Synchronizer, window/edge counters, latch and display next values.
    always_comb begin
        sync1_d     = mprj_io[8];
        sync2_d     = sync1_q;
        sync_prev_d = sync2_q;
        win_d       = win_q;
        edge_cnt_d  = edge_cnt_q;
        latch_d     = latch_q;
        edge_sum    = edge_cnt_q + {31'd0, rise};
        display_d   = latch_q;
        digit_d     = ~digit_q;
        if (count_en) begin
            if (win_q == period_w - 32'd1) begin
                win_d      = 32'd0;
                edge_cnt_d = 32'd0;
                latch_d    = sat99(edge_sum);
            end else begin
                win_d      = win_q + 32'd1;
                edge_cnt_d = edge_sum;
            end
        end
    end

    // Measurement and display registers; reset discards any partial window.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync_prev_q <= 1'b0;
            win_q       <= 32'd0;
            edge_cnt_q  <= 32'd0;
            latch_q     <= 7'd0;
            display_q   <= 7'd0;
            digit_q     <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync_prev_q <= sync_prev_d;
            win_q       <= win_d;
            edge_cnt_q  <= edge_cnt_d;
            latch_q     <= latch_d;
            display_q   <= display_d;
            digit_q     <= digit_d;
        end
    end

    // Segment mux: digit high shows tens, digit low shows units.
    always_comb begin
        if (digit_q) seg_w = seg_encode(display_q / 7'd10);
        else         seg_w = seg_encode(display_q % 7'd10);
    end

endmodule

// File: tb/tb_caravel_frequency_counter.sv
// Bench for caravel_frequency_counter: table-driven signal patterns, random
// patterns against a window-counting reference model, reset and flash cases.
module tb_caravel_frequency_counter;

    localparam int P_DEF = 1000;
    localparam logic [6:0] SEG [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    localparam int M_RAND  = -1;
    localparam int M_RANDF = -2;
`ifdef FREQ_COUNTER_FLASH_CFG_EN
    localparam int START_INIT = -1;
`else
    localparam int START_INIT = 0;
`endif

    logic clock = 1'b0;
    logic resetb = 1'b0;
    logic sig = 1'b0;
    logic flash_io1 = 1'b0;
    logic pwr_hi = 1'b1;
    logic pwr_lo = 1'b0;
    wire [37:0] mprj_io;
    wire        gpio;
    wire        flash_csb, flash_clk, flash_io0;
    wire [6:0]  seg = mprj_io[15:9];
    wire        dig = mprj_io[16];

    assign mprj_io[8] = sig;

    int checks = 0;
    int failures = 0;
    int model_period = P_DEF;
    int start_idx = START_INIT;
    bit hist[$];
    logic [31:0] fl_rd = 32'hFFFF_FFFF;

    caravel_frequency_counter #(.DEFAULT_PERIOD(P_DEF)) dut (
        .vddio(pwr_hi), .vssio(pwr_lo), .vdda(pwr_hi), .vssa(pwr_lo),
        .vccd(pwr_hi), .vssd(pwr_lo), .vdda1(pwr_hi), .vdda2(pwr_hi),
        .vssa1(pwr_lo), .vssa2(pwr_lo), .vccd1(pwr_hi), .vccd2(pwr_hi),
        .vssd1(pwr_lo), .vssd2(pwr_lo),
        .clock(clock), .resetb(resetb), .mprj_io(mprj_io), .gpio(gpio),
        .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0),
        .flash_io1(flash_io1)
    );

    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

`ifdef FREQ_COUNTER_FLASH_CFG_EN
    bit csb_was_low = 1'b0;
    logic [31:0] cmd_cap = 32'd0;
    int fl_n = 0;
    bit fl_prev = 1'b0;

    // Flash responder: records MOSI on SCK rise, presents the next data bit after SCK fall.
    always @(negedge clock) begin
        if (!resetb) begin
            fl_n <= 0;
            fl_prev <= 1'b0;
            cmd_cap <= 32'd0;
            flash_io1 <= 1'b0;
        end else if (!flash_csb) begin
            if (flash_clk && !fl_prev) begin
                fl_n <= fl_n + 1;
                if (fl_n < 32) cmd_cap <= {cmd_cap[30:0], flash_io0};
            end else if (!flash_clk && fl_prev) begin
                if (fl_n >= 32 && fl_n <= 63) flash_io1 <= fl_rd[63 - fl_n];
            end
            fl_prev <= flash_clk;
        end
    end
`endif

    // Input history per clock edge since reset release; also notes where counting begins.
    always @(posedge clock) begin
        if (!resetb) begin
            hist.delete();
            start_idx <= START_INIT;
`ifdef FREQ_COUNTER_FLASH_CFG_EN
            csb_was_low <= 1'b0;
`endif
        end else begin
`ifdef FREQ_COUNTER_FLASH_CFG_EN
            if (start_idx < 0) begin
                if (!flash_csb) csb_was_low <= 1'b1;
                else if (csb_was_low) start_idx <= hist.size();
            end
`endif
            hist.push_back(sig);
        end
    end

    function automatic int sel_period(input logic [31:0] rd);
        if (rd == 32'd0 || rd == 32'd1 || rd == 32'hFFFF_FFFF) return P_DEF;
        return int'(rd);
    endfunction

    function automatic bit hv(input int j);
        if (j < 0 || j >= hist.size()) return 1'b0;
        return hist[j];
    endfunction

    // Expected displayed value: rising input transitions seen two edges late,
    // counted over the most recently finished window, clamped to 99.
    function automatic int model_disp();
        int n, c, k, cnt, e;
        n = hist.size();
        if (start_idx < 0) return 0;
        c = n - 1 - start_idx;
        if (c < model_period) return 0;
        k = c / model_period - 1;
        cnt = 0;
        for (int i = 0; i < model_period; i++) begin
            e = start_idx + k * model_period + i;
            if (hv(e - 2) && !hv(e - 3)) cnt++;
        end
        return (cnt > 99) ? 99 : cnt;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic cmp_model(input string name, input int tbl_val);
        int ev;
        bit ed;
        logic [6:0] es;
        ev = model_disp();
        ed = (hist.size() % 2) != 0;
        es = ed ? SEG[ev / 10] : SEG[ev % 10];
        check({name, "_digit"}, 32'(dig), 32'(ed));
        check({name, "_seg"}, 32'(seg), 32'(es));
        if (tbl_val >= 0)
            check({name, "_tbl"}, 32'(seg), 32'(dig ? SEG[tbl_val / 10] : SEG[tbl_val % 10]));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_seg"}, 32'(seg), 32'h3F);
        check({name, "_digit"}, 32'(dig), 32'd0);
        check({name, "_csb"}, 32'(flash_csb), 32'd1);
        check({name, "_fclk"}, 32'(flash_clk), 32'd0);
        check({name, "_io0"}, 32'(flash_io0), 32'd0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clock);
        resetb = 1'b0;
        sig = 1'b0;
`ifdef FREQ_COUNTER_FLASH_CFG_EN
        model_period = sel_period(fl_rd);
`else
        model_period = P_DEF;
`endif
        repeat (2) @(negedge clock);
        check_reset_outputs(name);
        resetb = 1'b1;
    endtask

    // Drive a pattern for ncyc cycles; compare two consecutive cycles at chk_at
    // (both digits) and optionally every chk_every cycles.
    task automatic run(input string name, input int ncyc, input int mode,
                       input int chk_at, input int tbl_val, input int chk_every);
        int hold;
        hold = 0;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clock);
            if (t == chk_at || t == chk_at + 1) cmp_model(name, tbl_val);
            else if (chk_every > 0 && (t % chk_every) == chk_every - 1) cmp_model(name, -1);
            case (mode)
                0: sig = 1'b0;
                1: sig = 1'b1;
                2: sig = (t % 2) != 0;
                M_RAND, M_RANDF: begin
                    if (hold == 0) begin
                        sig = $urandom_range(0, 1) != 0;
                        hold = (mode == M_RAND) ? int'($urandom_range(1, 12))
                                                : int'($urandom_range(1, 3));
                    end
                    hold--;
                end
                default: sig = (t % mode) < (mode / 2);
            endcase
        end
    endtask

`ifdef FREQ_COUNTER_FLASH_CFG_EN
    task automatic flash_load(input string name);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clock);
            if (start_idx >= 0) begin
                ok = 1'b1;
                break;
            end
            if (t % 16 == 15) cmp_model({name, "_load"}, 0);
        end
        check({name, "_started"}, 32'(ok), 32'd1);
        check({name, "_cmd"}, cmd_cap, 32'h0300_0000);
        check({name, "_bits"}, 32'(fl_n), 32'd64);
    endtask
`endif

    typedef struct {
        string name;
        int    mode;
        int    exp_val;
    } vec_t;

    initial begin
        vec_t vecs[7];
        bit done;
        int cs;

        vecs[0] = '{"sq40", 40, 25};
        vecs[1] = '{"low", 0, 0};
        vecs[2] = '{"high", 1, 0};
        vecs[3] = '{"toggle", 2, 99};
        vecs[4] = '{"sq20", 20, 50};
        vecs[5] = '{"sq100", 100, 10};
        vecs[6] = '{"sq250", 250, 4};

        for (int i = 0; i < 7; i++) begin
            do_reset({vecs[i].name, "_rst"});
            run(vecs[i].name, 2 * P_DEF + 200, vecs[i].mode, 2 * P_DEF + 150, vecs[i].exp_val, 0);
`ifndef FREQ_COUNTER_FLASH_CFG_EN
            check({vecs[i].name, "_csb_idle"}, 32'(flash_csb), 32'd1);
            check({vecs[i].name, "_fclk_idle"}, 32'(flash_clk), 32'd0);
            check({vecs[i].name, "_io0_idle"}, 32'(flash_io0), 32'd0);
`endif
        end

        do_reset("rand_rst");
        run("rand", 3500, M_RAND, -10, -1, 151);
        do_reset("randf_rst");
        run("randf", 3500, M_RANDF, -10, -1, 137);

        // Reset in the middle of a window, then one fresh window before a reading.
        do_reset("mid_pre_rst");
        run("mid_pre", P_DEF + 600, 40, -10, -1, 0);
        @(negedge clock);
        resetb = 1'b0;
        #1;
        check_reset_outputs("mid_async");
        repeat (2) @(negedge clock);
        resetb = 1'b1;
        done = 1'b0;
        for (int t = 0; t < 2 * P_DEF + 400; t++) begin
            @(negedge clock);
            if (start_idx >= 0) begin
                cs = hist.size() - start_idx;
                if (cs == model_period) begin
                    check("mid_before_window_seg", 32'(seg), 32'h3F);
                    cmp_model("mid_before_window", -1);
                end
                if (cs == model_period + 1) begin
                    cmp_model("mid_first_window", 25);
                    done = 1'b1;
                end
            end
            sig = (t % 40) < 20;
            if (done) break;
        end
        check("mid_reached_window", 32'(done), 32'd1);

`ifdef FREQ_COUNTER_FLASH_CFG_EN
        fl_rd = 32'h0000_00C8;
        do_reset("fl200_rst");
        flash_load("fl200");
        run("fl200", 2 * 200 + 60, 10, 2 * 200 + 20, 20, 23);

        fl_rd = 32'h0000_0001;
        do_reset("fl1_rst");
        flash_load("fl1");
        run("fl1", 2 * P_DEF + 100, 40, 2 * P_DEF + 50, 25, 0);

        fl_rd = 32'hFFFF_FFFF;
        do_reset("flff_rst");
        flash_load("flff");
        run("flff", 2 * P_DEF + 100, 40, 2 * P_DEF + 50, 25, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/caravel_frequency_counter.md
CARAVEL_FREQUENCY_COUNTER -- requirements
Module: caravel_frequency_counter

Interface
REQ-001 Parameter DEFAULT_PERIOD, default 1000: measurement window length in clock cycles; legal range 2 to 2^32-1.
REQ-002 clock  input  1  system clock; all logic on its rising edge.
REQ-003 resetb  input  1  reset, asynchronous, active-low.
REQ-004 mprj_io  inout  38  bit 8 = measured signal (input); bits 15:9 = segments[6:0] (output); bit 16 = digit select (output); all other bits high-Z.
REQ-005 gpio  inout  1  unused; high-Z.
REQ-006 flash_csb  output  1  SPI flash chip select, active-low.
REQ-007 flash_clk  output  1  SPI flash clock.
REQ-008 flash_io0  output  1  SPI MOSI.
REQ-009 flash_io1  input  1  SPI MISO.
REQ-010 Power pins vddio, vssio, vdda, vssa, vccd, vssd, vdda1, vdda2, vssa1, vssa2, vccd1, vccd2, vssd1, vssd2: 1-bit inputs with no functional effect.

Function
REQ-011 mprj_io[8] SHALL pass through a 2-flop synchronizer; a rising edge is a synced 0->1 transition.
REQ-012 Window counter SHALL run 0..PERIOD-1 and wrap; edge counter counts rising edges within the window.
REQ-013 On the window's last cycle, the count SHALL be latched, including any edge in that cycle; the edge counter then restarts from 0.
REQ-014 Latched value SHALL saturate at 99; the displayed value updates 1 cycle after the latch.
REQ-015 Displayed value SHALL split into tens and units (value/10, value%10), both 0..9.
REQ-016 digit (mprj_io[16]) SHALL toggle every clock cycle.
REQ-017 digit=1: segments show tens; digit=0: segments show units.
REQ-018 Segments are active-high, bit0=a .. bit6=g.
REQ-019 Segment encoding SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
REQ-020 Before the first window completes, the displayed value SHALL be 0.

Reset
REQ-021 While resetb=0:
- segments = 0x3F
- digit = 0
- all counters = 0
- synchronizer = 0
- flash_csb = 1, flash_clk = 0, flash_io0 = 0.
REQ-022 Reset asserted mid-window SHALL discard the partial count; after release, measurement restarts with a fresh window.

Configuration
REQ-023 With macro FREQ_COUNTER_FLASH_CFG_EN defined, after reset release the block SHALL read the period from flash and only then start counting:
- pull flash_csb low
- send 0x03 plus 24-bit address 0x000000, MSB first on flash_io0; flash_clk = clock/2
- change flash_io0 while flash_clk is low; sample flash_io1 on the flash_clk rising edge
- read 4 bytes, big-endian, as the period
- raise flash_csb.
REQ-024 With FREQ_COUNTER_FLASH_CFG_EN defined, a read value of 0, 1 or 0xFFFFFFFF SHALL select DEFAULT_PERIOD.
REQ-025 With FREQ_COUNTER_FLASH_CFG_EN defined, the display SHALL hold 0 during the flash load.
REQ-026 Without FREQ_COUNTER_FLASH_CFG_EN:
- period = DEFAULT_PERIOD
- counting starts the first cycle after reset release
- flash_csb held 1, flash_clk and flash_io0 held 0.

Verification
REQ-027 Macro off, DEFAULT_PERIOD=1000, signal period 40 clocks -> count 25; digit=1 segments 0x5B, digit=0 segments 0x6D.
REQ-028 Signal held constant -> 00; segments 0x3F on both digits.
REQ-029 Signal toggling every clock (500 edges per window) -> saturates to 99; segments 0x6F on both digits.
REQ-030 Reset pulsed mid-window -> segments 0x3F immediately; next valid reading appears one full window after release.
REQ-031 Macro on, flash bytes 00 00 00 C8 (period 200), signal period 10 -> count 20; segments 0x5B (tens) and 0x3F (units); check the SPI command sequence 03 00 00 00.
REQ-032 Macro on, flash bytes FF FF FF FF -> DEFAULT_PERIOD used; repeat REQ-027 -> same result.
